// File: rtl/apb_uart_bridge.sv
// rtl/apb_uart_bridge.sv - APB slave UART bridge with TX/RX FIFOs, baud divisor and interrupt
//
// Parameters:
//   DATA_W           UART payload bits per frame (8..32)
//   FIFO_DEPTH       entries per TX and RX FIFO (power of two, >= 2)
//   CLKS_PER_BIT_RST reset value of the BAUD register
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE     APB control
//   PADDR[3:0], PWDATA[31:0] APB address (word index in [3:2]) and write data
//   PRDATA[31:0]            read data, non-zero only in a successful read access phase
//   PREADY, PSLVERR         always ready; error on DATA full/empty accesses
//   rx                      serial input (asynchronous)
//   tx, tx_busy             serial output (idles high) and frame-in-progress flag
//   irq                     registered level interrupt
// Register map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC BAUD.

module apb_uart_bridge #(
    parameter int DATA_W           = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int CLKS_PER_BIT_RST = 1042
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        rx,
    output logic        tx,
    output logic        tx_busy,
    output logic        irq
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int BW        = $clog2(DATA_W);
    localparam int DATA_W_M1 = DATA_W - 1;
    localparam logic [BW-1:0] LAST_BIT = DATA_W_M1[BW-1:0];
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_BAUD   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // ------------------------------------------------------------------
    // Registers and shared state
    // ------------------------------------------------------------------
    logic [3:0]  ctrl;        // {tx_irq_en, rx_irq_en, rx_en, tx_en}
    logic [15:0] baud;
    logic        overrun;
    logic        frame_err;

    logic        apb_acc;
    logic        wr_evt;
    logic        rd_evt;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;

    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign apb_acc = PSEL & PENABLE;
    assign wr_evt  = apb_acc & PWRITE;
    assign rd_evt  = apb_acc & ~PWRITE;
    assign reg_sel = PADDR[3:2];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr_ptr;
    logic [AW-1:0]     tx_rd_ptr;
    logic [AW:0]       tx_count;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_pop_data;

    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_empty    = (tx_count == '0);
    // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
    assign tx_push     = wr_evt & (reg_sel == A_DATA) & ~tx_full;
    assign tx_pop_data = tx_mem[tx_rd_ptr];

    always_ff @(posedge PCLK) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= PWDATA[DATA_W-1:0];
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr_ptr;
    logic [AW-1:0]     rx_rd_ptr;
    logic [AW:0]       rx_count;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_push_pend;
    logic [DATA_W-1:0] rx_shreg;
    logic [DATA_W-1:0] rx_pop_data;

    assign rx_full     = (rx_count == FULL_CNT);
    assign rx_empty    = (rx_count == '0);
    assign rx_push     = rx_push_pend & ~rx_full;
    assign rx_pop      = rd_evt & (reg_sel == A_DATA) & ~rx_empty;
    assign rx_pop_data = rx_mem[rx_rd_ptr];

    always_ff @(posedge PCLK) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_shreg;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // APB read path and error response
    // ------------------------------------------------------------------
    assign PREADY  = 1'b1;
    assign PSLVERR = (wr_evt & (reg_sel == A_DATA) & tx_full) |
                     (rd_evt & (reg_sel == A_DATA) & rx_empty);

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            A_DATA:   rd_mux[DATA_W-1:0] = rx_pop_data;
            A_STATUS: rd_mux[6:0] = {tx_busy, frame_err, overrun,
                                     rx_empty, rx_full, tx_empty, tx_full};
            A_CTRL:   rd_mux[3:0]  = ctrl;
            default:  rd_mux[15:0] = baud;
        endcase
    end

    assign PRDATA = (rd_evt & ~PSLVERR) ? rd_mux : 32'd0;

    // ------------------------------------------------------------------
    // TX state machine; tx/tx_busy are driven from the current state, so
    // the line lags the state by one cycle uniformly across every bit.
    // ------------------------------------------------------------------
    uart_state_t       tx_state;
    logic [15:0]       tx_baud;
    logic [15:0]       tx_cnt;
    logic [BW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_baud - 16'd1);
    // A pop at the end of STOP chains the next frame with no idle gap.
    assign tx_pop = ctrl[0] & ~tx_empty &
                    ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_end));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_state <= S_IDLE;
            tx_baud  <= 16'd4;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE:  begin tx <= 1'b1;        tx_busy <= 1'b0; end
                S_START: begin tx <= 1'b0;        tx_busy <= 1'b1; end
                S_DATA:  begin tx <= tx_shreg[0]; tx_busy <= 1'b1; end
                default: begin tx <= 1'b1;        tx_busy <= 1'b1; end
            endcase

            if (tx_pop) begin
                tx_state <= S_START;
                tx_baud  <= baud;
                tx_cnt   <= '0;
                tx_shreg <= tx_pop_data;
            end else if (tx_state != S_IDLE) begin
                if (!tx_bit_end) begin
                    tx_cnt <= tx_cnt + 16'd1;
                end else begin
                    tx_cnt <= '0;
                    case (tx_state)
                        S_START: begin
                            tx_state <= S_DATA;
                            tx_bit   <= '0;
                        end
                        S_DATA: begin
                            tx_shreg <= tx_shreg >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                            if (tx_bit == LAST_BIT) tx_state <= S_STOP;
                        end
                        default: tx_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and state machine. After the start-bit mid sample
    // the counter restarts, so every later sample lands a full bit later.
    // ------------------------------------------------------------------
    uart_state_t   rx_state;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic          rx_fall;
    logic [15:0]   rx_baud;
    logic [15:0]   rx_cnt;
    logic [15:0]   rx_half;
    logic [BW-1:0] rx_bit;
    logic          rx_bit_end;
    logic          rx_set_frame_err;
    logic          rx_set_overrun;

    assign rx_fall          = rx_prev & ~rx_s2;
    assign rx_half          = {1'b0, rx_baud[15:1]};
    assign rx_bit_end       = (rx_cnt == rx_baud - 16'd1);
    assign rx_set_frame_err = (rx_state == S_STOP) & rx_bit_end & ~rx_s2;
    assign rx_set_overrun   = rx_push_pend & rx_full;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_state     <= S_IDLE;
            rx_baud      <= 16'd4;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shreg     <= '0;
            rx_push_pend <= 1'b0;
        end else begin
            rx_push_pend <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (ctrl[1] && rx_fall) begin
                        rx_state <= S_START;
                        rx_baud  <= baud;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == rx_half) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A line already back high is a glitch, not a start bit.
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == LAST_BIT) rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_cnt       <= '0;
                        rx_state     <= S_IDLE;
                        // The word is committed on the following edge.
                        rx_push_pend <= rx_s2;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control/status registers and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl      <= 4'h3;
            baud      <= 16'(CLKS_PER_BIT_RST);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_evt && reg_sel == A_CTRL) begin
                ctrl <= PWDATA[3:0];
            end
            if (wr_evt && reg_sel == A_BAUD) begin
                baud <= (PWDATA[15:0] < 16'd4) ? 16'd4 : PWDATA[15:0];
            end
            // A new error on the same edge as a clear wins over the clear.
            if (rx_set_overrun) begin
                overrun <= 1'b1;
            end else if (wr_evt && reg_sel == A_STATUS && PWDATA[4]) begin
                overrun <= 1'b0;
            end
            if (rx_set_frame_err) begin
                frame_err <= 1'b1;
            end else if (wr_evt && reg_sel == A_STATUS && PWDATA[5]) begin
                frame_err <= 1'b0;
            end
            irq <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_empty) | overrun | frame_err;
        end
    end

endmodule

// File: tb/tb_apb_uart_bridge.sv
// tb/tb_apb_uart_bridge.sv - directed scoreboard bench for apb_uart_bridge

module tb_apb_uart_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int BT    = 16;
    localparam int NBITS = DW + 2;

    localparam logic [3:0] R_DATA   = 4'h0;
    localparam logic [3:0] R_STATUS = 4'h4;
    localparam logic [3:0] R_CTRL   = 4'h8;
    localparam logic [3:0] R_BAUD   = 4'hC;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        rx_line, tx, tx_busy, irq;
    logic        rx_drv, loop_en;

    int n_cmp;
    int n_fail;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 PCLK = ~PCLK;

    apb_uart_bridge #(
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT_RST(1042)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .rx(rx_line),
        .tx(tx),
        .tx_busy(tx_busy),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK iff 1'b0 or posedge PCLK);
        err = PSLVERR;
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        d   = PRDATA;
        err = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Counts edges until tx goes low; the caller compares against the required latency.
    task automatic wait_tx_fall(output int lat);
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            @(posedge PCLK);
            #1;
            lat++;
        end
    endtask

    // Starts 1 time unit after the edge on which the start bit appeared.
    task automatic tx_frame_check(input string tag);
        logic [31:0] exp_w;
        logic [31:0] got;
        logic        exp_bit;
        int          bad;
        int          busy_lo;
        bad = 0; busy_lo = 0; got = '0;
        if (tx_q.size() > 0) exp_w = tx_q.pop_front();
        else exp_w = 32'hxxxxxxxx;
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < BT; c++) begin
                if (i == 0) exp_bit = 1'b0;
                else if (i == NBITS - 1) exp_bit = 1'b1;
                else exp_bit = exp_w[i-1];
                if (tx !== exp_bit) bad++;
                if (tx_busy !== 1'b1) busy_lo++;
                if (i >= 1 && i <= DW && c == BT / 2) got[i-1] = tx;
                @(posedge PCLK);
                #1;
            end
        end
        check({tag, "_word"}, got, exp_w);
        check({tag, "_bad_bit_cycles"}, bad, 0);
        check({tag, "_busy_low_cycles"}, busy_lo, 0);
    endtask

    task automatic send_rx(input logic [31:0] w, input logic stop_bit);
        @(negedge PCLK);
        rx_drv = 1'b0;
        repeat (BT) @(negedge PCLK);
        for (int i = 0; i < DW; i++) begin
            rx_drv = w[i];
            repeat (BT) @(negedge PCLK);
        end
        rx_drv = stop_bit;
        repeat (BT) @(negedge PCLK);
        rx_drv = 1'b1;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic read_data_expect(input string tag);
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_w;
        if (rx_q.size() > 0) exp_w = rx_q.pop_front();
        else exp_w = 32'hxxxxxxxx;
        apb_read(R_DATA, d, e);
        check({tag, "_data"}, d, exp_w);
        check({tag, "_pslverr"}, {31'd0, e}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          model_cnt;
        logic [31:0] pats [5];

        pats[0] = 32'h0F0F0F0F;
        pats[1] = 32'h80000001;
        pats[2] = 32'hFFFFFFFF;
        pats[3] = 32'h00000000;
        pats[4] = 32'h13572468;

        n_cmp = 0; n_fail = 0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        rx_drv = 1'b1; loop_en = 1'b0;
        PRESET = 1'b1;

        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_tx_in_reset", {31'd0, tx}, 32'd1);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_prdata_idle", PRDATA, 32'd0);
        check("reset_pslverr_idle", {31'd0, PSLVERR}, 32'd0);
        check("pready", {31'd0, PREADY}, 32'd1);
        apb_read(R_STATUS, rd, err);
        check("reset_status", rd, 32'h0000000A);
        apb_read(R_BAUD, rd, err);
        check("reset_baud", rd, 32'd1042);
        apb_read(R_CTRL, rd, err);
        check("reset_ctrl", rd, 32'h3);

        // BAUD floor of 4, then working value
        apb_write(R_BAUD, 32'd2, err);
        apb_read(R_BAUD, rd, err);
        check("baud_floor", rd, 32'd4);
        apb_write(R_BAUD, BT, err);
        apb_read(R_BAUD, rd, err);
        check("baud_16", rd, BT);

        // tx_irq_en with an empty TX FIFO raises irq
        apb_write(R_CTRL, 32'hB, err);
        repeat (2) @(posedge PCLK);
        #1;
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        apb_write(R_CTRL, 32'h3, err);
        repeat (2) @(posedge PCLK);
        #1;
        check("irq_tx_empty_off", {31'd0, irq}, 32'd0);

        // Single TX frame
        tx_q.push_back(32'h12345678);
        apb_write(R_DATA, 32'h12345678, err);
        check("tx1_pslverr", {31'd0, err}, 32'd0);
        wait_tx_fall(lat);
        check("tx1_latency", lat, 2);
        check("tx1_busy_rise", {31'd0, tx_busy}, 32'd1);
        tx_frame_check("tx1");
        check("tx1_idle_tx", {31'd0, tx}, 32'd1);
        check("tx1_busy_fall", {31'd0, tx_busy}, 32'd0);

        // Loopback of two back-to-back frames
        apb_write(R_CTRL, 32'h2, err);
        loop_en = 1'b1;
        tx_q.push_back(32'hDEADBEEF); rx_q.push_back(32'hDEADBEEF);
        apb_write(R_DATA, 32'hDEADBEEF, err);
        tx_q.push_back(32'h00000001); rx_q.push_back(32'h00000001);
        apb_write(R_DATA, 32'h00000001, err);
        apb_write(R_CTRL, 32'h3, err);
        wait_tx_fall(lat);
        check("lb_latency", lat, 2);
        tx_frame_check("lb_f1");
        check("lb_b2b_start", {31'd0, tx}, 32'd0);
        check("lb_b2b_busy", {31'd0, tx_busy}, 32'd1);
        tx_frame_check("lb_f2");
        check("lb_busy_fall", {31'd0, tx_busy}, 32'd0);
        repeat (4) @(posedge PCLK);
        loop_en = 1'b0;
        read_data_expect("lb_rd1");
        read_data_expect("lb_rd2");
        apb_read(R_DATA, rd, err);
        check("lb_rd3_pslverr", {31'd0, err}, 32'd1);
        check("lb_rd3_prdata", rd, 32'd0);

        // Framing error
        #1;
        check("fe_irq_before", {31'd0, irq}, 32'd0);
        send_rx(32'hA5A5A5A5, 1'b0);
        check("fe_irq", {31'd0, irq}, 32'd1);
        apb_read(R_STATUS, rd, err);
        check("fe_status", rd, 32'h0000002A);
        apb_write(R_STATUS, 32'h2F, err);
        apb_read(R_STATUS, rd, err);
        check("fe_cleared_status", rd, 32'h0000000A);
        check("fe_irq_cleared", {31'd0, irq}, 32'd0);

        // Overrun: five frames into a four-entry FIFO
        model_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (model_cnt < DEPTH) begin
                rx_q.push_back(pats[k]);
                model_cnt++;
            end
            send_rx(pats[k], 1'b1);
        end
        apb_read(R_STATUS, rd, err);
        check("ovr_status", rd, 32'h00000016);
        check("ovr_irq", {31'd0, irq}, 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            read_data_expect($sformatf("ovr_rd%0d", k));
        end
        apb_read(R_DATA, rd, err);
        check("ovr_rd_empty_pslverr", {31'd0, err}, 32'd1);
        check("ovr_rd_empty_prdata", rd, 32'd0);
        apb_write(R_STATUS, 32'h10, err);
        apb_read(R_STATUS, rd, err);
        check("ovr_cleared_status", rd, 32'h0000000A);

        // TX FIFO full with tx_en=0
        apb_write(R_CTRL, 32'h2, err);
        for (int k = 0; k < DEPTH + 1; k++) begin
            apb_write(R_DATA, 32'h100 + k, err);
            check($sformatf("txfull_wr%0d_pslverr", k), {31'd0, err},
                  (k < DEPTH) ? 32'd0 : 32'd1);
        end
        apb_read(R_STATUS, rd, err);
        check("txfull_status", rd, 32'h00000009);
        check("txfull_tx_idle", {31'd0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
